// File: rtl/bcd_serial_addsub.sv
// Digit-serial signed BCD add/subtract: one digit per clock LSD first, DIGITS (or 2*DIGITS for negative sub) cycles.
// No backpressure: start is sampled only when not busy; done pulses once per completed operation.
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout,
  output logic                  neg,
  output logic                  err,
  output logic                  busy,
  output logic                  done
);

  localparam int KW = $clog2(DIGITS);
  localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_FIX, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [4*DIGITS-1:0]  a_r, b_r;
  logic                 sub_r;
  logic                 carry;
  logic [KW-1:0]        k;

  logic [3:0] a_dig, b_dig, res_dig;
  logic [3:0] op_x, op_y;
  logic [4:0] sum;
  logic [3:0] slice_d;
  logic       slice_c;
  logic       last;
  logic       start_acc;
  logic       in_err;

  assign a_dig     = a_r[{k, 2'b00} +: 4];
  assign b_dig     = b_r[{k, 2'b00} +: 4];
  assign res_dig   = result[{k, 2'b00} +: 4];
  assign last      = (k == K_LAST);
  assign start_acc = start && ((state == S_IDLE) || (state == S_DONE));
  assign busy      = (state == S_ADD) || (state == S_FIX);
  assign done      = (state == S_DONE);

  // Single-digit slice shared by the add pass and the re-complement pass.
  always_comb begin
    op_x = a_dig;
    op_y = sub_r ? (4'd9 - b_dig) : b_dig;
    if (state == S_FIX) begin
      op_x = 4'd9 - res_dig;
      op_y = 4'd0;
    end
    sum     = {1'b0, op_x} + {1'b0, op_y} + {4'b0000, carry};
    slice_c = (sum > 5'd9);
    slice_d = slice_c ? (sum[3:0] + 4'd6) : sum[3:0];
  end

  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) in_err = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_ADD;
      S_ADD: begin
        if (last) state_nxt = (sub_r && !slice_c) ? S_FIX : S_DONE;
      end
      S_FIX:  if (last) state_nxt = S_DONE;
      S_DONE: state_nxt = start ? S_ADD : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      sub_r  <= 1'b0;
      carry  <= 1'b0;
      k      <= '0;
      result <= '0;
      cout   <= 1'b0;
      neg    <= 1'b0;
      err    <= 1'b0;
    end else if (start_acc) begin
      a_r    <= a;
      b_r    <= b;
      sub_r  <= sub;
      carry  <= sub;
      k      <= '0;
      result <= '0;
      cout   <= 1'b0;
      neg    <= 1'b0;
      err    <= in_err;
    end else if (state == S_ADD) begin
      result[{k, 2'b00} +: 4] <= slice_d;
      if (last) begin
        k <= '0;
        // No final carry on subtract means A<B: ten's-complement the result.
        if (sub_r && !slice_c) begin
          carry <= 1'b1;
        end else begin
          carry <= slice_c;
          cout  <= slice_c;
        end
      end else begin
        k     <= k + 1'b1;
        carry <= slice_c;
      end
    end else if (state == S_FIX) begin
      result[{k, 2'b00} +: 4] <= slice_d;
      carry <= slice_c;
      if (last) begin
        k    <= '0;
        cout <= 1'b0;
        neg  <= 1'b1;
      end else begin
        k <= k + 1'b1;
      end
    end
  end

endmodule

// File: doc/bcd_serial_addsub.md
# bcd_serial_addsub

Digit-serial, multi-digit signed BCD adder/subtractor. It latches two DIGITS-wide packed BCD operands, then processes one BCD digit per clock, least-significant digit first, through a single-digit BCD add slice with 9's-complement operand inversion and a registered decimal carry. For subtraction with a negative result, a second serial pass re-complements the result so the output is always sign + magnitude. The block sits directly downstream of operand entry and upstream of display/formatting logic, extending the single-digit BCD add/subtract stage to N digits.

## Interface
Parameters:
- DIGITS, 4 — number of BCD digits per operand/result (≥2)

Ports:
- clk  input  1  — single clock, rising edge
- rst_n  input  1  — reset, asynchronous and active-low
- start  input  1  — request operation; sampled only when busy=0
- sub  input  1  — 0: A+B, 1: A−B; latched with operands on accepted start
- a  input  4*DIGITS  — operand A, packed BCD, digit 0 = bits [3:0]
- b  input  4*DIGITS  — operand B, packed BCD
- result  output  4*DIGITS  — packed BCD result (magnitude for sub)
- cout  output  1  — add: decimal overflow carry; sub: 1 when A≥B
- neg  output  1  — sub only: 1 when A<B (result is |A−B|); always 0 for add
- err  output  1  — 1 if any latched operand digit >9
- busy  output  1  — high in ADD and FIX states
- done  output  1  — one-cycle pulse when result/cout/neg/err are valid

## Operation
- States: IDLE, ADD, FIX, DONE.
- IDLE/DONE: busy=0; start=1 latches a, b, sub, clears result, sets digit index k=0, loads carry register with sub, and goes to ADD. start in ADD/FIX is ignored; operands are not relatched.
- ADD (DIGITS cycles): digit slice computes A[k] + (sub ? 9−B[k] : B[k]) + carry. BCD correction: add 6 when the binary sum >9, decimal carry = (sum>9). Digit written to result[k], carry register updated, k increments.
- After the last ADD digit: if sub=1 and final carry=0, go to FIX with k=0 and carry=1. Otherwise cout=final carry, neg=0, go to DONE.
- FIX (DIGITS cycles): result[k] ← (9−result[k]) + carry with BCD correction, i.e. ten's complement of the result. Then cout=0, neg=1, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. Outputs hold their values until the next accepted start.
- 9's complement of a digit: 9−d for d≤9.
- Invalid digits (>9): err is set when any latched digit of a or b exceeds 9. Computation still runs with the same arithmetic. The result is unspecified but done still pulses and timing is unchanged.
- Carry between digits is held in a flip-flop only; there is no combinational ripple across digits.

## Timing
- Reset values: result=0, cout=0, neg=0, err=0, busy=0, done=0, state=IDLE, k=0, carry=0.
- Reset asserted mid-operation: immediate return to reset values. No done pulse for the aborted operation.
- Start accepted on rising edge E0. busy=1 from E0 until the edge that enters DONE.
- Add, or sub with A≥B: DONE entered at edge E0+DIGITS. done is high for the cycle after that edge.
- Sub with A<B: DONE entered at E0+2·DIGITS.
- start high while in DONE is accepted: the new operation begins the next cycle, and done still pulses for the completed one.
- result digits update one per cycle during ADD/FIX. Intermediate values are not valid until done.

## Test plan
- DIGITS=4, add 1234+5678 → result 6912, cout=0, neg=0; done exactly 4 cycles after the start edge.
- Add 9999+0001 → result 0000, cout=1; a 6-correction occurs on every digit.
- Sub 5000−1234 → result 3766, cout=1, neg=0; latency 4 cycles.
- Sub 1234−5000 → result 3766, cout=0, neg=1; latency 8 cycles (FIX pass exercised). Sub 0000−0000 → 0000, cout=1, neg=0.
- start pulsed again 2 cycles into a busy operation with different operands → ignored; original result delivered. Then rst_n pulsed low mid-ADD → all outputs 0, no done pulse, next start works normally.
- Add with a=00A0, b=0001 → err=1 at done, done timing unchanged. A following valid add clears err=0.
